// File: rtl/arith_pkg.sv
// Shared arithmetic constants for leaf adder cells.
package arith_pkg;

  // Upper bound on operand width accepted by the adder family.
  localparam int FA_MAX_WIDTH = 64;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder cell; chained by the parent to form a ripple-carry adder.
module full_adder_bit
  import arith_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  // Propagate term is shared between sum and carry.
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder.sv
// Parameterised ripple-carry adder: {cout, sum} = a + b + c, optionally registered.
module full_adder
  import arith_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int REG_OUT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Catch illegal widths at elaboration rather than producing a broken netlist.
  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
    $error("full_adder: WIDTH %0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
  end

  logic [WIDTH:0]   k;     // carry chain, k[0] is carry-in
  logic [WIDTH-1:0] s_c;   // combinational sum

  assign k[0] = c;

  // One cell per bit, carry rippling from LSB to MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_bit (
      .a  (a[i]),
      .b  (b[i]),
      .ci (k[i]),
      .s  (s_c[i]),
      .co (k[i+1])
    );
  end

  if (REG_OUT != 0) begin : g_reg
    // Output register; reset clears the result asynchronously and drops any pending value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum  <= '0;
        cout <= 1'b0;
      end else begin
        sum  <= s_c;
        cout <= k[WIDTH];
      end
    end
  end else begin : g_comb
    // Clock and reset are intentionally ignored in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign sum  = s_c;
    assign cout = k[WIDTH];
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder in combinational and registered builds.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=1 combinational, clock/reset tied off
  logic       a1, b1, c1, s1, co1;
  // WIDTH=8 combinational and registered, shared inputs
  logic [7:0] a8, b8, s8c, s8r;
  logic       c8, co8c, co8r;
  // WIDTH=16 combinational and registered, shared inputs
  logic [15:0] a16, b16, s16c, s16r;
  logic        c16, co16c, co16r;

  full_adder #(.WIDTH(1), .REG_OUT(0)) u_w1 (
    .clk(1'b0), .rst_n(1'b0), .a(a1), .b(b1), .c(c1), .sum(s1), .cout(co1));
  full_adder #(.WIDTH(8), .REG_OUT(0)) u_w8c (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8), .sum(s8c), .cout(co8c));
  full_adder #(.WIDTH(8), .REG_OUT(1)) u_w8r (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8), .sum(s8r), .cout(co8r));
  full_adder #(.WIDTH(16), .REG_OUT(0)) u_w16c (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .c(c16), .sum(s16c), .cout(co16c));
  full_adder #(.WIDTH(16), .REG_OUT(1)) u_w16r (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .c(c16), .sum(s16r), .cout(co16r));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition, widened so no carry is lost.
  function automatic logic [63:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                          input logic ci, input int w);
    logic [63:0] r;
    logic [63:0] mask;
    mask = (64'd1 << (w + 1)) - 64'd1;
    r = (x + y + {63'd0, ci}) & mask;
    return r;
  endfunction

  logic [63:0] prev8 = 64'd0;
  logic [63:0] prev16 = 64'd0;

  // Apply one WIDTH=8 vector: comb is immediate, registered lags one edge.
  task automatic step8(input logic [7:0] x, input logic [7:0] y, input logic ci, input string tag);
    logic [63:0] e;
    @(negedge clk);
    a8 = x; b8 = y; c8 = ci;
    e = ref_add({56'd0, x}, {56'd0, y}, ci, 8);
    #1;
    chk({tag, "_comb"}, {55'd0, co8c, s8c}, e);
    chk({tag, "_reg_pre"}, {55'd0, co8r, s8r}, prev8);
    @(posedge clk); #1;
    chk({tag, "_reg_post"}, {55'd0, co8r, s8r}, e);
    prev8 = e;
  endtask

  task automatic step16(input logic [15:0] x, input logic [15:0] y, input logic ci);
    logic [63:0] e;
    @(negedge clk);
    a16 = x; b16 = y; c16 = ci;
    e = ref_add({48'd0, x}, {48'd0, y}, ci, 16);
    #1;
    chk("rnd16_comb", {47'd0, co16c, s16c}, e);
    chk("rnd16_reg_pre", {47'd0, co16r, s16r}, prev16);
    @(posedge clk); #1;
    chk("rnd16_reg_post", {47'd0, co16r, s16r}, e);
    prev16 = e;
  endtask

  initial begin
    logic [2:0] v;
    a1 = 0; b1 = 0; c1 = 0;
    a8 = 8'hA5; b8 = 8'h3C; c8 = 1'b1;
    a16 = '0; b16 = '0; c16 = 1'b0;

    // Reset state: registered outputs 0 despite nonzero inputs and running clock
    repeat (2) @(posedge clk);
    #1;
    chk("reset_w8r", {55'd0, co8r, s8r}, 64'd0);
    chk("reset_w16r", {47'd0, co16r, s16r}, 64'd0);

    // WIDTH=1 truth table, 10 ns steps, no clock on this instance
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      {a1, b1, c1} = v;
      #10;
      chk($sformatf("w1_tt_%0d", i), {62'd0, co1, s1},
          ref_add({63'd0, v[2]}, {63'd0, v[1]}, v[0], 1));
    end
    a1 = 1; b1 = 1; c1 = 1; #1;
    chk("w1_111_noclk", {62'd0, co1, s1}, 64'd3);

    @(negedge clk);
    rst_n = 1'b1;
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;

    // WIDTH=8 directed vectors
    step8(8'h00, 8'h00, 1'b0, "w8_zero");
    step8(8'hFF, 8'h00, 1'b1, "w8_ripple");
    step8(8'h5A, 8'h33, 1'b0, "w8_5a33");
    step8(8'h80, 8'h80, 1'b1, "w8_8080");
    step8(8'hFF, 8'hFF, 1'b1, "w8_allones");
    for (int i = 0; i < 6; i++)
      step8(8'($urandom), 8'($urandom), 1'($urandom), "w8_track");

    // Make output nonzero, then assert reset between edges
    step8(8'hF0, 8'h0F, 1'b1, "w8_prerst");
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    chk("rst_async_w8r", {55'd0, co8r, s8r}, 64'd0);
    @(posedge clk); #1;
    chk("rst_hold_w8r", {55'd0, co8r, s8r}, 64'd0);
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b1;
    rst_n = 1'b1; #1;
    chk("rst_release_pre", {55'd0, co8r, s8r}, 64'd0);
    @(posedge clk); #1;
    chk("rst_release_post", {55'd0, co8r, s8r}, 64'h47);
    prev8 = 64'h47;

    // WIDTH=16 random regression
    prev16 = 64'd0;
    for (int i = 0; i < 1000; i++)
      step16(16'($urandom), 16'($urandom), 1'($urandom));
    step16(16'hFFFF, 16'hFFFF, 1'b1);
    step16(16'h0000, 16'h0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: run exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
